qsfp_link_ctrl: RTL and testbench
=================================

Name: qsfp_link_ctrl

Overview:
Bring-up and supervision controller for one QSFP28 cage and its Ethernet GT/MAC core. It sequences the clock-generator reset, module reset, low-power mode and the GT core reset. It debounces module presence and waits for GT lock with timeout and bounded retry. It reports link state and status to the RISC-V SoC.
The block sits inside the board Ethernet wrapper, between the cage pins and the Ethernet core reset/status.

Parameters:
T_REFCLK, 1000, cycles refclk_reset is held high (1..2^24-1)
T_RESETL, 1000, cycles qsfp_resetl is held low after refclk release (1..2^24-1)
T_INIT, 200000, cycles waited after resetl release before GT reset (1..2^24-1)
T_LOCK, 100000, cycles allowed for gt_ready after GT reset (1..2^24-1)
T_DEBOUNCE, 1000, cycles the synchronized modprsl must be stable before presence changes (1..2^24-1)
MAX_RETRY, 3, lock timeouts tolerated before FAULT (0..15)
FS, 2'b11, constant frequency-select value driven on qsfp_fs

Ports:
clock  input  1  single clock domain; all logic posedge
reset  input  1  synchronous, active-high
enable  input  1  software link enable; low forces OFF
qsfp_modprsl  input  1  module present, active-low, asynchronous
qsfp_intl  input  1  module interrupt, active-low, asynchronous
gt_ready  input  1  GT/MAC lock/alignment status, asynchronous
qsfp_modsell  output  1  module select, active-low
qsfp_resetl  output  1  module reset, active-low
qsfp_lpmode  output  1  module low-power mode
qsfp_refclk_reset  output  1  reference clock generator reset
qsfp_fs  output  2  clock generator frequency select
gt_reset  output  1  reset to Ethernet GT/MAC core, active-high
link_up  output  1  link usable
status  output  8  {intl_n_sync, present, fault, link_up, 1'b0, state[2:0]}
event  output  1  one-cycle pulse on a status change of interest

Behaviour:
- Reset values:
  - modsell=1, resetl=0, lpmode=1, refclk_reset=1, fs=FS, gt_reset=1
  - link_up=0, event=0, state=OFF, present=0, fault=0, retry=0
- Input synchronization:
  - qsfp_modprsl, qsfp_intl and gt_ready each pass through a 2-FF synchronizer.
  - present updates to !modprsl_sync only after modprsl_sync has differed from the current value for T_DEBOUNCE consecutive cycles.
  - Any bounce restarts the debounce count.
- Timer:
  - One 24-bit down-counter, loaded with T-1 on state entry.
  - A timed state exits on the cycle its counter is 0, so it lasts exactly T cycles.
- State encodings: OFF=0, REFCLK_RST=1, MOD_RESET=2, MOD_INIT=3, GT_RST=4, WAIT_LOCK=5, UP=6, FAULT=7.
- OFF: outputs at reset values. Go to REFCLK_RST when enable && present.
- REFCLK_RST: refclk_reset=1, resetl=0. Go to MOD_RESET after T_REFCLK cycles.
- MOD_RESET: refclk_reset=0, resetl=0. Go to MOD_INIT after T_RESETL cycles.
- MOD_INIT: resetl=1, lpmode=0, modsell=0. Go to GT_RST after T_INIT cycles.
- GT_RST: gt_reset=1 for exactly 16 cycles, then WAIT_LOCK.
- WAIT_LOCK: gt_reset=0.
  - If gt_ready_sync: go to UP, clear retry.
  - Else, when the T_LOCK timer expires:
    - if retry==MAX_RETRY, go to FAULT;
    - otherwise retry++ and go to GT_RST.
- UP: link_up=1. gt_ready_sync low causes link_up=0 the next cycle and entry to GT_RST; retry is not incremented.
- FAULT: fault=1, gt_reset=1, module outputs held as in MOD_INIT. Leave only via enable low (to OFF). fault clears on entry to OFF.
- Global abort: from any state, !enable or !present forces OFF the next cycle. This has priority over every other transition, including a simultaneous timer expiry or gt_ready.
- event: pulses for 1 cycle on each of the following:
  - entry to UP
  - exit from UP
  - entry to FAULT
  - change of present
  - falling edge of intl_n_sync
  
  Simultaneous causes produce a single pulse.
- reset asserted mid-sequence: all outputs return to reset values on the next edge; no residual timer or retry state.

Optional Feature:
QSFP_INTL_RETRAIN_EN:
- Defined: a falling edge of intl_n_sync while in UP forces GT_RST (link_up drops next cycle), in addition to the event pulse.
- Undefined: intl only sets status[7] and pulses event; the state machine ignores it.

Test Plan:
- Parameters T_REFCLK=4, T_RESETL=5, T_INIT=6, T_LOCK=20, T_DEBOUNCE=3, MAX_RETRY=2 apply to all scenarios.
- Normal bring-up:
  - Stimulus: modprsl=0, enable=1, gt_ready rises 10 cycles after GT_RST exit.
  - Response: refclk_reset high 4 cycles; resetl low 5 more cycles; GT_RST 16 cycles; UP reached; link_up=1, status[2:0]=6, one event pulse.
- Lock timeout:
  - Stimulus: gt_ready held 0.
  - Response: 3 WAIT_LOCK windows of 20 cycles with GT_RST between them; then FAULT, status[5]=1, gt_reset=1; enable toggle 1→0→1 restarts at REFCLK_RST.
- Presence bounce:
  - Stimulus: modprsl 2-cycle glitch high while in UP.
  - Response: no state change, no event. Holding modprsl high 3+ cycles gives OFF within 3+2+1 cycles, link_up=0, resetl=0, one event.
- Link loss:
  - Stimulus: gt_ready drops in UP.
  - Response: link_up=0 and GT_RST entered (after sync latency), retry stays 0; relock restores UP.
- Reset mid-sequence:
  - Stimulus: reset pulsed during MOD_INIT.
  - Response: next edge shows all reset values. With QSFP_INTL_RETRAIN_EN defined, an intl falling edge in UP re-enters GT_RST; without it, the state stays UP and only event pulses.

Source files
------------

// File: rtl/qsfp_link_ctrl.sv
// qsfp_link_ctrl: bring-up and supervision of one QSFP28 cage and its Ethernet GT/MAC core.
// Optional `QSFP_INTL_RETRAIN_EN: a module interrupt while UP forces a GT retrain.
module qsfp_link_ctrl #(
   parameter int unsigned T_REFCLK   = 1000,
   parameter int unsigned T_RESETL   = 1000,
   parameter int unsigned T_INIT     = 200000,
   parameter int unsigned T_LOCK     = 100000,
   parameter int unsigned T_DEBOUNCE = 1000,
   parameter int unsigned MAX_RETRY  = 3,
   parameter logic [1:0]  FS         = 2'b11
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       qsfp_modprsl,
   input  logic       qsfp_intl,
   input  logic       gt_ready,
   output logic       qsfp_modsell,
   output logic       qsfp_resetl,
   output logic       qsfp_lpmode,
   output logic       qsfp_refclk_reset,
   output logic [1:0] qsfp_fs,
   output logic       gt_reset,
   output logic       link_up,
   output logic [7:0] status,
   output logic       link_event
);
   typedef enum logic [2:0] {OFF, REFCLK_RST, MOD_RESET, MOD_INIT, GT_RST, WAIT_LOCK, UP, FAULT} state_t;
   localparam logic [23:0] L_REFCLK = 24'(T_REFCLK - 1);
   localparam logic [23:0] L_RESETL = 24'(T_RESETL - 1);
   localparam logic [23:0] L_INIT   = 24'(T_INIT - 1);
   localparam logic [23:0] L_LOCK   = 24'(T_LOCK - 1);
   localparam logic [23:0] L_DB     = 24'(T_DEBOUNCE - 1);
   localparam logic [3:0]  R_MAX    = 4'(MAX_RETRY);
   state_t state, state_n;
   logic [1:0] prsl_s, intl_s, rdy_s;
   logic [23:0] tmr, tmr_load, db_cnt;
   logic [3:0] retry;
   logic present, present_n, flip, intl_fall, retrain, expired;
   // presence flips on the last cycle of a full stable window; abort tracks that same edge
   assign flip = prsl_s[1] == present && db_cnt == L_DB;
   assign present_n = present ^ flip;
   assign intl_fall = intl_s[1] & ~intl_s[0];
   assign expired = tmr == '0;
`ifdef QSFP_INTL_RETRAIN_EN
   assign retrain = intl_fall;
`else
   assign retrain = 1'b0;
`endif
   assign tmr_load = state_n == REFCLK_RST ? L_REFCLK :
                     state_n == MOD_RESET  ? L_RESETL :
                     state_n == MOD_INIT   ? L_INIT   :
                     state_n == GT_RST     ? 24'd15   :
                     state_n == WAIT_LOCK  ? L_LOCK   : '0;
   always_comb begin
      state_n = state;
      case (state)
         OFF:        state_n = enable && present ? REFCLK_RST : OFF;
         REFCLK_RST: state_n = expired ? MOD_RESET : state;
         MOD_RESET:  state_n = expired ? MOD_INIT : state;
         MOD_INIT:   state_n = expired ? GT_RST : state;
         GT_RST:     state_n = expired ? WAIT_LOCK : state;
         WAIT_LOCK:  state_n = rdy_s[1] ? UP : !expired ? WAIT_LOCK : retry == R_MAX ? FAULT : GT_RST;
         UP:         state_n = !rdy_s[1] || retrain ? GT_RST : UP;
         default:    state_n = state;
      endcase
      if (!enable || !present_n) state_n = OFF;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         prsl_s     <= 2'b11;
         intl_s     <= 2'b11;
         rdy_s      <= 2'b00;
         present    <= 1'b0;
         db_cnt     <= '0;
         state      <= OFF;
         tmr        <= '0;
         retry      <= '0;
         link_event <= 1'b0;
      end else begin
         prsl_s     <= {prsl_s[0], qsfp_modprsl};
         intl_s     <= {intl_s[0], qsfp_intl};
         rdy_s      <= {rdy_s[0], gt_ready};
         present    <= present_n;
         db_cnt     <= prsl_s[1] == present && !flip ? db_cnt + 24'd1 : '0;
         state      <= state_n;
         tmr        <= state_n != state ? tmr_load : expired ? tmr : tmr - 24'd1;
         retry      <= state_n == UP || state_n == OFF ? '0 :
                       state == WAIT_LOCK && state_n == GT_RST ? retry + 4'd1 : retry;
         link_event <= (state_n == UP) != (state == UP) || (state_n == FAULT && state != FAULT) || flip || intl_fall;
      end
   end
   assign qsfp_refclk_reset = state == OFF || state == REFCLK_RST;
   assign qsfp_resetl = state >= MOD_INIT;
   assign qsfp_modsell = ~qsfp_resetl;
   assign qsfp_lpmode = ~qsfp_resetl;
   assign qsfp_fs = FS;
   assign gt_reset = !(state == WAIT_LOCK || state == UP);
   assign link_up = state == UP;
   assign status = {intl_s[1], present, state == FAULT, link_up, 1'b0, state};
endmodule

// File: tb/tb_qsfp_link_ctrl.sv
// tb_qsfp_link_ctrl: directed scenarios plus random stimulus against a cycle-stepped behavioural model.
module tb_qsfp_link_ctrl;
   localparam int TR = 4, TL = 5, TI = 6, TK = 20, TD = 3, MR = 2;
   logic clock = 0, reset = 1, enable = 0, qsfp_modprsl = 1, qsfp_intl = 1, gt_ready = 0;
   logic qsfp_modsell, qsfp_resetl, qsfp_lpmode, qsfp_refclk_reset, gt_reset, link_up, link_event;
   logic [1:0] qsfp_fs;
   logic [7:0] status, pins;
   int total = 0, bad = 0, evts = 0;
   int dwell[8];
   always #5 clock = ~clock;
   assign pins = {qsfp_modsell, qsfp_resetl, qsfp_lpmode, qsfp_refclk_reset, qsfp_fs, gt_reset, link_up};

   qsfp_link_ctrl #(.T_REFCLK(TR), .T_RESETL(TL), .T_INIT(TI), .T_LOCK(TK), .T_DEBOUNCE(TD),
                    .MAX_RETRY(MR), .FS(2'b11)) dut (
      .clock(clock), .reset(reset), .enable(enable), .qsfp_modprsl(qsfp_modprsl),
      .qsfp_intl(qsfp_intl), .gt_ready(gt_ready), .qsfp_modsell(qsfp_modsell),
      .qsfp_resetl(qsfp_resetl), .qsfp_lpmode(qsfp_lpmode), .qsfp_refclk_reset(qsfp_refclk_reset),
      .qsfp_fs(qsfp_fs), .gt_reset(gt_reset), .link_up(link_up), .status(status),
      .link_event(link_event));

   // pin table per state: {modsell, resetl, lpmode, refclk_reset, fs[1:0], gt_reset, link_up}
   logic [7:0] pin_tab [8] = '{8'b1011_1110, 8'b1011_1110, 8'b1010_1110, 8'b0100_1110,
                               8'b0100_1110, 8'b0100_1100, 8'b0100_1101, 8'b0100_1110};
   int m_st, m_age, m_retry, m_stable;
   bit m_present, m_evt;
   bit prsl_q[$], intl_q[$], rdy_q[$];

   function automatic int dur(int s);
      return s == 1 ? TR : s == 2 ? TL : s == 3 ? TI : s == 4 ? 16 : s == 5 ? TK : 0;
   endfunction

   task automatic model(input bit r, input bit e, input bit p, input bit i, input bit g);
      bit np, fall, retrain, last;
      int nxt;
      if (r) begin
         m_st = 0; m_age = 0; m_retry = 0; m_stable = 0; m_present = 0; m_evt = 0;
         prsl_q = '{1'b1, 1'b1}; intl_q = '{1'b1, 1'b1}; rdy_q = '{1'b0, 1'b0};
         return;
      end
      np = m_present;
      if (!prsl_q[0] != m_present) begin
         m_stable++;
         if (m_stable == TD) begin np = !prsl_q[0]; m_stable = 0; end
      end else m_stable = 0;
      fall = intl_q[0] && !intl_q[1];
`ifdef QSFP_INTL_RETRAIN_EN
      retrain = fall;
`else
      retrain = 0;
`endif
      last = m_age == dur(m_st) - 1;
      nxt = m_st;
      case (m_st)
         0: if (e && m_present) nxt = 1;
         1, 2, 3, 4: if (last) nxt = m_st + 1;
         5: if (rdy_q[0]) nxt = 6; else if (last) nxt = m_retry == MR ? 7 : 4;
         6: if (!rdy_q[0] || retrain) nxt = 4;
         default: ;
      endcase
      if (!e || !np) nxt = 0;
      m_evt = ((nxt == 6) != (m_st == 6)) || (nxt == 7 && m_st != 7) || np != m_present || fall;
      if (nxt == 0 || nxt == 6) m_retry = 0;
      else if (m_st == 5 && nxt == 4) m_retry++;
      m_age = nxt == m_st ? m_age + 1 : 0;
      m_st = nxt;
      m_present = np;
      prsl_q.push_back(p); void'(prsl_q.pop_front());
      intl_q.push_back(i); void'(intl_q.pop_front());
      rdy_q.push_back(g); void'(rdy_q.pop_front());
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         model(reset, enable, qsfp_modprsl, qsfp_intl, gt_ready);
         #1;
         chk("status", {24'd0, status}, {24'd0, intl_q[0], m_present, m_st == 7, m_st == 6, 1'b0, 3'(m_st)});
         chk("pins", {24'd0, pins}, {24'd0, pin_tab[m_st]});
         chk("event", {31'd0, link_event}, {31'd0, m_evt});
         dwell[status[2:0]]++;
         if (link_event) evts++;
      end
   endtask

   task automatic wait_state(input int s, input int lim, input string tag);
      int k = 0;
      while (status[2:0] != 3'(s) && k < lim) begin step(1); k++; end
      chk(tag, {29'd0, status[2:0]}, s);
   endtask

   task automatic clr();
      foreach (dwell[i]) dwell[i] = 0;
      evts = 0;
   endtask

   initial begin
      step(3);
      chk("rst_pins", {24'd0, pins}, 32'hBE);
      chk("rst_status", {24'd0, status}, 32'h80);
      chk("rst_event", {31'd0, link_event}, 0);
      // normal bring-up
      reset = 0; enable = 1; qsfp_modprsl = 0;
      clr();
      wait_state(5, 200, "reach_wait_lock");
      chk("refclk_cycles", dwell[1], 4);
      chk("resetl_cycles", dwell[2], 5);
      chk("init_cycles", dwell[3], 6);
      chk("gt_rst_cycles", dwell[4], 16);
      evts = 0;
      step(9);
      gt_ready = 1;
      wait_state(6, 20, "reach_up");
      chk("up_link", {31'd0, link_up}, 1);
      chk("up_events", evts, 1);
      // link loss and relock
      gt_ready = 0;
      wait_state(4, 10, "loss_gt_rst");
      chk("loss_link", {31'd0, link_up}, 0);
      gt_ready = 1;
      wait_state(6, 40, "relock");
      // presence glitch then real removal
      clr();
      qsfp_modprsl = 1; step(2); qsfp_modprsl = 0; step(10);
      chk("bounce_state", {29'd0, status[2:0]}, 6);
      chk("bounce_events", evts, 0);
      qsfp_modprsl = 1;
      wait_state(0, 6, "removal_off");
      step(2);
      chk("removal_events", evts, 1);
      chk("removal_resetl", {31'd0, qsfp_resetl}, 0);
      // lock timeout to FAULT
      qsfp_modprsl = 0; gt_ready = 0;
      wait_state(4, 100, "to_gt_rst");
      clr();
      wait_state(7, 400, "fault");
      chk("wait_lock_cycles", dwell[5], 3 * TK);
      chk("fault_bit", {31'd0, status[5]}, 1);
      chk("fault_gt_reset", {31'd0, gt_reset}, 1);
      step(5);
      chk("fault_hold", {29'd0, status[2:0]}, 7);
      enable = 0; step(2);
      chk("fault_off", {29'd0, status[2:0]}, 0);
      enable = 1;
      wait_state(1, 5, "restart");
      // reset during MOD_INIT
      wait_state(3, 40, "mod_init");
      reset = 1; step(1);
      chk("midrst_pins", {24'd0, pins}, 32'hBE);
      chk("midrst_status", {24'd0, status}, 32'h80);
      reset = 0;
      // module interrupt while UP
      gt_ready = 1;
      wait_state(6, 200, "up_again");
      evts = 0;
      qsfp_intl = 0; step(4);
`ifdef QSFP_INTL_RETRAIN_EN
      chk("intl_state", {29'd0, status[2:0]}, 4);
`else
      chk("intl_state", {29'd0, status[2:0]}, 6);
`endif
      chk("intl_events", evts, 1);
      chk("intl_status7", {31'd0, status[7]}, 0);
      qsfp_intl = 1; step(3);
      // random traffic, checked cycle by cycle against the model
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 299) == 0) enable = ~enable;
         if ($urandom_range(0, 59) == 0) qsfp_modprsl = ~qsfp_modprsl;
         if ($urandom_range(0, 39) == 0) gt_ready = ~gt_ready;
         if ($urandom_range(0, 49) == 0) qsfp_intl = ~qsfp_intl;
         reset = $urandom_range(0, 999) == 0;
         step(1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
